// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the HI/LO multiply/divide unit.
// The control decoder imports the same types, so the MULT/DIV/MTHI/MTLO/
// MFHI/MFLO request codes live in exactly one place.
package mips_pkg;

    // Request codes presented on hilo_muldiv_unit.op
    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_MFHI  = 3'd6,
        OP_MFLO  = 3'd7
    } hilo_op_t;

    // Sequencer states of the multiply/divide unit
    typedef enum logic [1:0] {
        MD_IDLE   = 2'd0,
        MD_MUL    = 2'd1,
        MD_DIV    = 2'd2,
        MD_COMMIT = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/seq_divider.sv
// seq_divider: iterative unsigned restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 load dividend/divisor and begin ITER steps
//   dividend, divisor     unsigned operands (sampled when start=1)
//   done                  high during the cycle that performs the last step
//   quotient, remainder   results, valid the cycle after done
// Dividing by zero yields quotient=all ones, remainder=dividend.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(ITER + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        // Partial remainder shifted left with the next dividend bit brought in
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_q};
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CW'(ITER);
            run_d = 1'b1;
        end else if (run_q) begin
            // diff[WIDTH] is the borrow: set means the subtraction is undone
            if (!diff[WIDTH]) begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign done      = run_q && (cnt_q == CW'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: multi-cycle multiply/divide unit owning the HI/LO pair.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start, op    request valid and request code (mips_pkg::hilo_op_t)
//   a, b         rs / rt operands
//   stall        request not accepted this cycle (start & busy)
//   rd_data      HI for MFHI, LO for MFLO, otherwise 0
//   busy         mul/div in progress (MUL, DIV or COMMIT)
//   done         one-cycle pulse in the commit cycle
//   hi, lo       architectural HI/LO
// Handshake: a request is accepted on any clock edge where start=1 and
// stall=0; while stall=1 the decoder keeps start/op/a/b stable.
module hilo_muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             stall,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(ITER + 1);

    muldiv_state_t      state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               dz_q, dz_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    hilo_op_t           op_e;
    logic               sgn_op;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod_fix;
    logic               div_start, div_done;
    logic [WIDTH-1:0]   div_quo, div_rem;

    assign op_e   = hilo_op_t'(op);
    assign sgn_op = (op_e == OP_MULT) || (op_e == OP_DIV);
    assign mag_a  = (sgn_op && a[WIDTH-1]) ? -a : a;
    assign mag_b  = (sgn_op && b[WIDTH-1]) ? -b : b;

    seq_divider #(.WIDTH(WIDTH), .ITER(ITER)) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (div_start),
        .dividend  (mag_a),
        .divisor   (mag_b),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        is_div_d  = is_div_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        div_start = 1'b0;
        // Shift-add step: add multiplicand to the upper half when the
        // current multiplier bit (acc[0]) is set, then shift right.
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        prod_fix  = neg_res_q ? -acc_q : acc_q;

        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    case (op_e)
                        OP_MULT, OP_MULTU: begin
                            state_d   = MD_MUL;
                            cnt_d     = CW'(ITER);
                            acc_d     = {{WIDTH{1'b0}}, mag_b};
                            mcand_d   = mag_a;
                            neg_res_d = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = 1'b0;
                            dz_d      = 1'b0;
                            is_div_d  = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = MD_DIV;
                            cnt_d     = CW'(ITER);
                            div_start = 1'b1;
                            neg_res_d = sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem_d = sgn_op && a[WIDTH-1];
                            dz_d      = (b == '0);
                            is_div_d  = 1'b1;
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            MD_MUL: begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = MD_COMMIT;
            end
            MD_DIV: begin
                cnt_d = cnt_q - CW'(1);
                if (div_done) state_d = MD_COMMIT;
            end
            MD_COMMIT: begin
                if (is_div_q) begin
                    // Divide by zero bypasses the quotient sign fix
                    lo_d = dz_q ? '1 : (neg_res_q ? -div_quo : div_quo);
                    hi_d = neg_rem_q ? -div_rem : div_rem;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                cnt_d   = '0;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            is_div_q  <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            is_div_q  <= is_div_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy    = (state_q != MD_IDLE);
    assign done    = (state_q == MD_COMMIT);
    assign stall   = start && busy;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = (start && op_e == OP_MFHI) ? hi_q :
                     (start && op_e == OP_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit.
module tb_hilo_muldiv_unit;
    localparam int W    = 32;
    localparam int ITER = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         stall;
    logic [W-1:0] rd_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    hilo_muldiv_unit #(.WIDTH(W), .ITER(ITER)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .stall   (stall),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, hold it while stalled, return stall cycles and the
    // rd_data seen in the accepting cycle. Returns 1 unit after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                         output int stalls, output logic [W-1:0] rdv);
        start  = 1'b1;
        op     = o;
        a      = aa;
        b      = bb;
        stalls = 0;
        #1;
        while (stall && stalls < 200) begin
            stalls++;
            @(posedge clk);
            #2;
        end
        if (stalls >= 200) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: stall still high after %0d cycles", stalls);
        end
        rdv = rd_data;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            step();
        end
    endtask

    initial begin
        int          st;
        int          n;
        int          done_cnt;
        int          done_k;
        logic [W-1:0] rdv;

        rst_n = 1'b0;
        start = 1'b0;
        op    = 3'd0;
        a     = '0;
        b     = '0;
        #12;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_rd_data", rd_data, 32'h0);
        rst_n = 1'b1;
        step();

        // 1: MULTU max*max, MFHI the next cycle stalls through busy period
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, rdv);
        chk("t1_multu_stall", st, 32'd0);
        issue(3'd6, 32'h0, 32'h0, st, rdv);
        chk("t1_mfhi_stalls", st, ITER + 1);
        chk("t1_mfhi", rdv, 32'hFFFF_FFFE);
        issue(3'd7, 32'h0, 32'h0, st, rdv);
        chk("t1_mflo", rdv, 32'h0000_0001);
        chk("t1_mflo_stalls", st, 32'd0);

        // 2: DIV -7 / 2, done pulse timing
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, st, rdv);
        done_cnt = 0;
        done_k   = 0;
        for (int k = 1; k <= 40; k++) begin
            if (done) begin
                done_cnt++;
                done_k = k;
            end
            step();
        end
        chk("t2_done_count", done_cnt, 32'd1);
        chk("t2_done_cycle", done_k, ITER + 1);
        chk("t2_lo", lo, 32'hFFFF_FFFD);
        chk("t2_hi", hi, 32'hFFFF_FFFF);

        // 3: DIVU by zero
        issue(3'd3, 32'h0000_1234, 32'h0, st, rdv);
        wait_idle(n);
        chk("t3_busy_cycles", n, ITER + 1);
        chk("t3_lo", lo, 32'hFFFF_FFFF);
        chk("t3_hi", hi, 32'h0000_1234);

        // 4: MTHI/MTLO back to back, then MTLO stalled behind MULT
        issue(3'd4, 32'hDEAD_BEEF, 32'h0, st, rdv);
        chk("t4_mthi_stall", st, 32'd0);
        chk("t4_hi", hi, 32'hDEAD_BEEF);
        issue(3'd5, 32'h0000_0005, 32'h0, st, rdv);
        chk("t4_mtlo_stall", st, 32'd0);
        chk("t4_lo", lo, 32'h0000_0005);
        issue(3'd0, 32'd3, 32'hFFFF_FFFE, st, rdv);
        issue(3'd5, 32'h0000_0005, 32'h0, st, rdv);
        chk("t4_mtlo_stalls", st, ITER + 1);
        chk("t4_final_hi", hi, 32'hFFFF_FFFF);
        chk("t4_final_lo", lo, 32'h0000_0005);

        // 5: reset in the middle of a MULT
        issue(3'd0, 32'h8000_0000, 32'h8000_0000, st, rdv);
        repeat (9) step();
        chk("t5_busy_before", {31'b0, busy}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_hi", hi, 32'h0);
        chk("t5_rst_lo", lo, 32'h0);
        chk("t5_rst_busy", {31'b0, busy}, 32'h0);
        #1 rst_n = 1'b1;
        step();
        issue(3'd0, 32'h8000_0000, 32'h8000_0000, st, rdv);
        wait_idle(n);
        chk("t5_busy_cycles", n, ITER + 1);
        chk("t5_hi", hi, 32'h4000_0000);
        chk("t5_lo", lo, 32'h0);

        // 6: DIV overflow case, DIVU presented during COMMIT
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, st, rdv);
        n = 0;
        while (!done && n < 100) begin
            n++;
            step();
        end
        chk("t6_done_seen", {31'b0, done}, 32'h1);
        start = 1'b1;
        op    = 3'd3;
        a     = 32'd100;
        b     = 32'd7;
        #1;
        chk("t6_commit_stall", {31'b0, stall}, 32'h1);
        step();
        chk("t6_idle_stall", {31'b0, stall}, 32'h0);
        chk("t6_lo", lo, 32'h8000_0000);
        chk("t6_hi", hi, 32'h0);
        step();
        start = 1'b0;
        chk("t6_divu_busy", {31'b0, busy}, 32'h1);
        wait_idle(n);
        chk("t6_divu_lo", lo, 32'd14);
        chk("t6_divu_hi", hi, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
